op_rec_packer: RTL
==================

# op_rec_packer

Packs an incoming 32-bit word stream into op/payload records (`op` 32 bits, `pl` NUM bits) for the downstream record-consuming stage. Each packet is one header beat, captured as `op`, followed by zero or more payload beats whose `tuser` flags form the `pl` mask. It sits directly upstream of the struct-based record stage. It absorbs stream framing and delivers one record per packet on a valid/ready port.

## Interface
Parameters:
- NUM, 6, payload mask width; maximum number of payload beats recorded per packet (≥1).

Ports:
- clock  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- in_tdata  in  32  stream data
- in_tuser  in  1  per-beat flag; on payload beat i it becomes `pl[i]`
- in_tlast  in  1  last beat of packet
- in_tvalid  in  1  stream valid
- in_tready  out  1  stream ready
- rec_op  out  32  record op (header word)
- rec_pl  out  NUM  record payload mask
- rec_cnt  out  $clog2(NUM+1)  number of payload beats recorded (0..NUM)
- rec_err  out  1  packet carried more than NUM payload beats
- rec_valid  out  1  record valid
- rec_ready  in  1  record ready

Clock is `clock`. Reset is synchronous, active-high, named `rst`.

## Operation
- A beat transfers when `in_tvalid && in_tready`. A record transfers when `rec_valid && rec_ready`.
- FSM states: HEAD, BODY, HOLD.
  - HEAD: `in_tready=1`. On transfer, load `op←tdata`, `pl←0`, `cnt←0`, `err←0`. If `tlast=1`, go to HOLD; otherwise go to BODY.
  - BODY: `in_tready=1`. On transfer, if `cnt<NUM` then `pl[cnt]←tuser` and `cnt←cnt+1`; otherwise set `err←1` and discard the beat. On `tlast=1`, go to HOLD.
  - HOLD: `in_tready=0`, `rec_valid=1`. On record transfer, go to HEAD.
- Record fields stay stable while `rec_valid=1 && !rec_ready`.
- Payload `tdata` is ignored. Only `tuser` is recorded.
- `cnt` saturates at NUM and never wraps. Bits of `pl` at index ≥ `cnt` are 0.
- Reset mid-packet: the partial packet is abandoned. After reset the next accepted beat is treated as a header, even if the upstream is mid-packet. Upstream resets together with this block.

## Timing
- Reset values:
  - `in_tready=0` in the reset cycle, 1 from the first cycle after `rst` deasserts (state HEAD).
  - `rec_valid=0`, `rec_op=0`, `rec_pl=0`, `rec_cnt=0`, `rec_err=0`.
- Latency: `rec_valid` rises in the cycle after the `tlast` beat transfers.
- Minimum packet period: header-only packet = 2 cycles (HEAD, HOLD with `rec_ready=1`). A packet of k payload beats = k+2 cycles.
- `in_tready` depends only on state (registered), never combinationally on `rec_ready`. There is no overlap between HOLD and acceptance of the next header; this is a deliberate one-bubble design.
- `rec_valid` does not depend combinationally on `rec_ready`. Once asserted, it deasserts only on transfer.

## Configuration
- `OP_REC_PACKER_ERR_CNT_EN` defined:
  - Adds output `err_cnt` (out, 16): count of records transferred with `rec_err=1`.
  - Increments on such a record transfer and saturates at 16'hFFFF.
  - Reset value is 0.
- Not defined: no `err_cnt` port and no counter logic. `rec_err` behaviour is unchanged.

## Structure
- Shared package `op_rec_pkg`:
  - `OP_W=32`.
  - State enum `{HEAD, BODY, HOLD}`.
  - Record struct typedef with `op[OP_W-1:0]`; the `pl` width is bound by the module parameter NUM, matching the downstream stage's struct layout.
- The module is flat; no sub-module is warranted at this size. The optional error counter is an inline `ifdef` block.

## Test plan
- Header-only packet: `tdata=32'hA5A5_0001`, `tlast=1` → one cycle later `rec_op=32'hA5A5_0001`, `rec_pl=0`, `rec_cnt=0`, `rec_err=0`.
- Header + 3 payload beats with tuser 1,0,1, NUM=6 → `rec_pl=6'b000101`, `rec_cnt=3`. `rec_valid` rises the cycle after the third payload beat.
- Header + 8 payload beats, all tuser=1, NUM=6 → `rec_pl=6'b111111`, `rec_cnt=6`, `rec_err=1`. With the macro defined, `err_cnt=1` after transfer.
- `rec_ready=0` for 5 cycles in HOLD → `in_tready=0` throughout, record fields stable; transfer occurs on the first `rec_ready=1` cycle.
- Back-to-back 2-beat packets with `rec_ready=1` → a record every 3 cycles with no beat loss.
- Assert `rst` after the header and 2 payload beats → no record emitted. The next beat (`tdata=32'h0000_00FF`, `tlast=1`) yields `rec_op=32'h0000_00FF`, `rec_cnt=0`.

Source files
------------

// File: rtl/op_rec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : op_rec_pkg
// Brief   : Shared op-width constant and packer state type for the
//           op/payload record path.
// Revision: 1.0 - initial release
// ============================================================================
package op_rec_pkg;

  localparam int OP_W = 32;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/op_rec_packer.sv
`default_nettype none
// ============================================================================
// Module  : op_rec_packer
// Brief   : Packs a header beat plus payload tuser flags into one op/payload
//           record per packet. Optional: OP_REC_PACKER_ERR_CNT_EN adds err_cnt.
// Revision: 1.0 - initial release
// ============================================================================
module op_rec_packer
  import op_rec_pkg::*;
#(
  parameter int NUM = 6
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [31:0]              in_tdata,
  input  logic                     in_tuser,
  input  logic                     in_tlast,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  output logic [OP_W-1:0]          rec_op,
  output logic [NUM-1:0]           rec_pl,
  output logic [$clog2(NUM+1)-1:0] rec_cnt,
  output logic                     rec_err,
  output logic                     rec_valid,
`ifdef OP_REC_PACKER_ERR_CNT_EN
  output logic [15:0]              err_cnt,
`endif
  input  logic                     rec_ready
);

  localparam int CW = $clog2(NUM + 1);

  // Record layout matches the downstream stage; pl width follows NUM.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [NUM-1:0]  pl;
    logic [CW-1:0]   cnt;
    logic            err;
  } rec_t;

  state_t state;
  rec_t   rec;
  logic   beat_xfer;
  logic   rec_xfer;

  assign beat_xfer = in_tvalid && in_tready;
  assign rec_xfer  = rec_valid && rec_ready;

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= HEAD;
      in_tready <= 1'b0;
      rec_valid <= 1'b0;
      rec       <= '0;
    end else begin
      case (state)
        HEAD: begin
          in_tready <= 1'b1;
          if (beat_xfer) begin
            rec.op  <= in_tdata;
            rec.pl  <= '0;
            rec.cnt <= '0;
            rec.err <= 1'b0;
            if (in_tlast) begin
              state     <= HOLD;
              in_tready <= 1'b0;
              rec_valid <= 1'b1;
            end else begin
              state <= BODY;
            end
          end
        end
        BODY: begin
          if (beat_xfer) begin
            // Beats beyond NUM are dropped; only the overflow flag remembers them.
            if (rec.cnt < CW'(NUM)) begin
              rec.pl[rec.cnt] <= in_tuser;
              rec.cnt         <= rec.cnt + CW'(1);
            end else begin
              rec.err <= 1'b1;
            end
            if (in_tlast) begin
              state     <= HOLD;
              in_tready <= 1'b0;
              rec_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (rec_xfer) begin
            state     <= HEAD;
            in_tready <= 1'b1;
            rec_valid <= 1'b0;
          end
        end
        default: begin
          state     <= HEAD;
          in_tready <= 1'b0;
          rec_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rec_op  = rec.op;
  assign rec_pl  = rec.pl;
  assign rec_cnt = rec.cnt;
  assign rec_err = rec.err;

`ifdef OP_REC_PACKER_ERR_CNT_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      err_cnt <= 16'd0;
    end else if (rec_xfer && rec.err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
